// File: rtl/qs_nios2_oci_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qs_nios2_oci_pkg
// Purpose  : Shared widths and state encoding for the OCI DCT trace packer.
// Contents : UNIT_W / UNITS / DCT_W / DCT_CNT_W, CNT_FULL, state_e.
// Revision : 1.0 - initial release
// ============================================================================
package qs_nios2_oci_pkg;

  localparam int UNIT_W    = 2;               // bits per trace code
  localparam int UNITS     = 15;              // trace codes per frame
  localparam int DCT_W     = UNIT_W * UNITS;  // 30-bit frame
  localparam int DCT_CNT_W = 4;               // holds 0..15

  localparam logic [DCT_CNT_W-1:0] CNT_FULL = DCT_CNT_W'(UNITS);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } state_e;

endpackage : qs_nios2_oci_pkg
`default_nettype wire

// File: rtl/qs_nios2_oci_dct_outreg.sv
`default_nettype none
// ============================================================================
// Module   : qs_nios2_oci_dct_outreg
// Purpose  : One-deep valid/ready output register for packed DCT frames.
//            A load always wins; otherwise the frame drops once accepted.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            load_i            - capture load_data_i/load_count_i this cycle
//            load_data_i/_count_i - frame contents to capture
//            ready_i           - consumer accepts the current frame
//            valid_o/data_o/count_o - registered frame outputs
//            free_o            - register can take a load this cycle
// Revision : 1.0 - initial release
// ============================================================================
module qs_nios2_oci_dct_outreg
  import qs_nios2_oci_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [DCT_W-1:0]     load_data_i,
  input  logic [DCT_CNT_W-1:0] load_count_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DCT_W-1:0]     data_o,
  output logic [DCT_CNT_W-1:0] count_o,
  output logic                 free_o
);

  logic                 valid_q;
  logic [DCT_W-1:0]     data_q;
  logic [DCT_CNT_W-1:0] count_q;

  // Free when empty or when the current frame leaves this cycle.
  assign free_o = !valid_q || ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
      count_q <= load_count_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule : qs_nios2_oci_dct_outreg
`default_nettype wire

// File: rtl/qs_nios2_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : qs_nios2_oci_dct_packer
// Purpose  : Packs 2-bit trace codes into 30-bit DCT frames (up to 15 units),
//            flushes partial frames on request / idle / end-of-test, and
//            sequences the test_ending -> test_has_ended drain.
// Ports    : tm_valid/tm_code/tm_ready   - trace code input handshake
//            flush_req                   - emit the partial buffer
//            test_ending/test_has_ended  - end-of-test drain handshake
//            frame_valid/data/count/ready - packed frame output handshake
//            dct_buffer/dct_count        - live accumulator view
// Revision : 1.0 - initial release
// ============================================================================
module qs_nios2_oci_dct_packer
  import qs_nios2_oci_pkg::*;
#(
  parameter int IDLE_FLUSH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tm_valid,
  input  logic [UNIT_W-1:0]    tm_code,
  output logic                 tm_ready,
  input  logic                 flush_req,
  input  logic                 test_ending,
  output logic                 frame_valid,
  output logic [DCT_W-1:0]     frame_data,
  output logic [DCT_CNT_W-1:0] frame_count,
  input  logic                 frame_ready,
  output logic [DCT_W-1:0]     dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic                 test_has_ended
);

  localparam int IDLE_W = (IDLE_FLUSH > 0) ? $clog2(IDLE_FLUSH + 1) : 1;
  // With IDLE_FLUSH == 0 the counter is pinned at zero and never triggers.
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_FLUSH);
  localparam logic              IDLE_EN  = (IDLE_FLUSH > 0);

  logic [DCT_W-1:0]     buf_q,   buf_d;
  logic [DCT_CNT_W-1:0] cnt_q,   cnt_d;
  logic [IDLE_W-1:0]    idle_q,  idle_d;
  logic                 flush_q, flush_d;
  state_e               state_q, state_d;
  logic                 ended_q, ended_d;

  logic w_out_free, w_accept, w_idle_hit, w_flush_now, w_xfer;

  qs_nios2_oci_dct_outreg u_outreg (
    .clk          (clk),
    .reset        (reset),
    .load_i       (w_xfer),
    .load_data_i  (buf_q),
    .load_count_i (cnt_q),
    .ready_i      (frame_ready),
    .valid_o      (frame_valid),
    .data_o       (frame_data),
    .count_o      (frame_count),
    .free_o       (w_out_free)
  );

  always_comb begin
    // Held low during reset so no code is taken while state is being cleared.
    tm_ready    = !reset && (state_q == RUN) && ((cnt_q != CNT_FULL) || w_out_free);
    w_accept    = tm_valid && tm_ready;
    w_idle_hit  = IDLE_EN && (idle_q == IDLE_MAX) && (cnt_q != '0);
    // New flush triggers act in the cycle they appear; flush_q keeps them
    // alive while the output register is blocked.
    w_flush_now = flush_q || flush_req || w_idle_hit || (state_q == DRAIN);
    w_xfer      = w_out_free && ((cnt_q == CNT_FULL) || (w_flush_now && (cnt_q != '0)));

    buf_d = buf_q;
    cnt_d = cnt_q;
    if (w_xfer && w_accept) begin
      buf_d = {{(DCT_W-UNIT_W){1'b0}}, tm_code};
      cnt_d = DCT_CNT_W'(1);
    end else if (w_xfer) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (w_accept) begin
      buf_d = {buf_q[DCT_W-UNIT_W-1:0], tm_code};
      cnt_d = cnt_q + DCT_CNT_W'(1);
    end

    // Requests against an empty buffer are dropped rather than remembered.
    flush_d = w_flush_now && !w_xfer && (cnt_q != '0);

    idle_d = idle_q;
    if (w_accept || w_xfer)   idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);

    state_d = state_q;
    case (state_q)
      RUN:     if (test_ending) state_d = DRAIN;
      DRAIN:   if ((cnt_q == '0) && !frame_valid) state_d = ENDED;
      ENDED:   state_d = ENDED;
      default: state_d = RUN;
    endcase

    ended_d = ended_q || (state_d == ENDED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      flush_q <= 1'b0;
      state_q <= RUN;
      ended_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      flush_q <= flush_d;
      state_q <= state_d;
      ended_q <= ended_d;
    end
  end

  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = ended_q;

endmodule : qs_nios2_oci_dct_packer
`default_nettype wire

// File: tb/tb_qs_nios2_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qs_nios2_oci_dct_packer
// Purpose  : Directed self-checking bench for the DCT trace packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qs_nios2_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tm_valid = 1'b0;
  logic [1:0]  tm_code = 2'd0;
  logic        tm_ready;
  logic        flush_req = 1'b0;
  logic        test_ending = 1'b0;
  logic        frame_valid;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic        frame_ready = 1'b1;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  qs_nios2_oci_dct_packer #(.IDLE_FLUSH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .tm_valid       (tm_valid),
    .tm_code        (tm_code),
    .tm_ready       (tm_ready),
    .flush_req      (flush_req),
    .test_ending    (test_ending),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .frame_count    (frame_count),
    .frame_ready    (frame_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tm_valid = 1'b0; frame_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (tm_ready !== 1'b0) begin n_err++; $display("FAIL reset_tm_ready got=%b exp=0", tm_ready); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end
    n_cmp++; if (frame_data !== 30'h0) begin n_err++; $display("FAIL reset_frame_data got=%h exp=0", frame_data); end
    n_cmp++; if (frame_count !== 4'd0) begin n_err++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
    n_cmp++; if (dct_buffer !== 30'h0) begin n_err++; $display("FAIL reset_dct_buffer got=%h exp=0", dct_buffer); end
    n_cmp++; if (dct_count !== 4'd0) begin n_err++; $display("FAIL reset_dct_count got=%0d exp=0", dct_count); end
    n_cmp++; if (test_has_ended !== 1'b0) begin n_err++; $display("FAIL reset_has_ended got=%b exp=0", test_has_ended); end
    reset = 1'b0;
    #1;
    n_cmp++; if (tm_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_tm_ready got=%b exp=1", tm_ready); end
  endtask

  task automatic test_full_frame();
    frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tm_valid = 1'b1; tm_code = 2'b01;
      tick();
    end
    tm_valid = 1'b0;
    n_cmp++; if (dct_count !== 4'd15) begin n_err++; $display("FAIL full_acc_count got=%0d exp=15", dct_count); end
    n_cmp++; if (dct_buffer !== 30'h15555555) begin n_err++; $display("FAIL full_acc_buffer got=%h exp=15555555", dct_buffer); end
    tick();
    n_cmp++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL full_frame_valid got=%b exp=1", frame_valid); end
    n_cmp++; if (frame_data !== 30'h15555555) begin n_err++; $display("FAIL full_frame_data got=%h exp=15555555", frame_data); end
    n_cmp++; if (frame_count !== 4'd15) begin n_err++; $display("FAIL full_frame_count got=%0d exp=15", frame_count); end
    n_cmp++; if (dct_count !== 4'd0) begin n_err++; $display("FAIL full_cleared_count got=%0d exp=0", dct_count); end
    tick();
    n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL full_consumed got=%b exp=0", frame_valid); end
  endtask

  task automatic test_back_to_back();
    frame_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tm_valid = 1'b1; tm_code = (i < 15) ? 2'b01 : 2'b10;
      #1;
      n_cmp++; if (tm_ready !== 1'b1) begin n_err++; $display("FAIL b2b_tm_ready idx=%0d got=%b exp=1", i, tm_ready); end
      tick();
      if (i == 15) begin
        n_cmp++; if (frame_valid !== 1'b1 || frame_count !== 4'd15 || frame_data !== 30'h15555555)
          begin n_err++; $display("FAIL b2b_frame1 got v=%b c=%0d d=%h exp v=1 c=15 d=15555555", frame_valid, frame_count, frame_data); end
        n_cmp++; if (dct_count !== 4'd1) begin n_err++; $display("FAIL b2b_16th_count got=%0d exp=1", dct_count); end
      end
    end
    tm_valid = 1'b0;
    n_cmp++; if (dct_count !== 4'd15) begin n_err++; $display("FAIL b2b_acc2_count got=%0d exp=15", dct_count); end
    tick();
    n_cmp++; if (frame_valid !== 1'b1 || frame_data !== 30'h2AAAAAAA || frame_count !== 4'd15)
      begin n_err++; $display("FAIL b2b_frame2 got v=%b c=%0d d=%h exp v=1 c=15 d=2aaaaaaa", frame_valid, frame_count, frame_data); end
    tick();
  endtask

  task automatic test_backpressure();
    frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tm_valid = 1'b1; tm_code = 2'b10;
      tick();
    end
    tm_code = 2'b11;
    #1;
    n_cmp++; if (tm_ready !== 1'b1) begin n_err++; $display("FAIL bp_16th_ready got=%b exp=1", tm_ready); end
    tick();
    n_cmp++; if (frame_valid !== 1'b1 || frame_data !== 30'h2AAAAAAA || dct_count !== 4'd1)
      begin n_err++; $display("FAIL bp_first_load got v=%b d=%h cnt=%0d exp v=1 d=2aaaaaaa cnt=1", frame_valid, frame_data, dct_count); end
    for (int i = 0; i < 14; i++) tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (tm_ready !== 1'b0 || dct_count !== 4'd15 || frame_data !== 30'h2AAAAAAA || frame_count !== 4'd15)
        begin n_err++; $display("FAIL bp_hold cyc=%0d got rdy=%b cnt=%0d d=%h fc=%0d exp rdy=0 cnt=15 d=2aaaaaaa fc=15", i, tm_ready, dct_count, frame_data, frame_count); end
      tick();
    end
    tm_valid = 1'b0; frame_ready = 1'b1;
    tick();
    n_cmp++; if (frame_valid !== 1'b1 || frame_data !== 30'h3FFFFFFF || dct_count !== 4'd0)
      begin n_err++; $display("FAIL bp_second_frame got v=%b d=%h cnt=%0d exp v=1 d=3fffffff cnt=0", frame_valid, frame_data, dct_count); end
    tick();
    n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got=%b exp=0", frame_valid); end
  endtask

  task automatic test_flush();
    logic [1:0] codes [3];
    codes[0] = 2'd3; codes[1] = 2'd2; codes[2] = 2'd1;
    frame_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tm_valid = 1'b1; tm_code = codes[i];
      tick();
    end
    tm_valid = 1'b0; flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n_cmp++; if (frame_valid !== 1'b1 || frame_data !== 30'h39 || frame_count !== 4'd3)
      begin n_err++; $display("FAIL flush_frame got v=%b d=%h c=%0d exp v=1 d=39 c=3", frame_valid, frame_data, frame_count); end
    n_cmp++; if (dct_count !== 4'd0) begin n_err++; $display("FAIL flush_cleared got=%0d exp=0", dct_count); end
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty_no_frame got=%b exp=0", frame_valid); end
  endtask

  task automatic test_idle_flush();
    bit seen = 1'b0;
    frame_ready = 1'b1;
    tm_valid = 1'b1; tm_code = 2'b10;
    tick();
    tm_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL idle_early got=%b exp=0", frame_valid); end
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (frame_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL idle_flush_timeout got v=0 exp v=1"); end
    else begin
      n_cmp++; if (frame_count !== 4'd1 || frame_data !== 30'h2)
        begin n_err++; $display("FAIL idle_frame got c=%0d d=%h exp c=1 d=2", frame_count, frame_data); end
    end
    tick();
  endtask

  task automatic test_drain();
    bit seen = 1'b0;
    frame_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tm_valid = 1'b1; tm_code = 2'b01;
      if (i == 4) test_ending = 1'b1;
      tick();
    end
    tm_valid = 1'b0;
    n_cmp++; if (tm_ready !== 1'b0) begin n_err++; $display("FAIL drain_tm_ready got=%b exp=0", tm_ready); end
    tick();
    n_cmp++; if (frame_valid !== 1'b1 || frame_count !== 4'd5 || frame_data !== 30'h155)
      begin n_err++; $display("FAIL drain_frame got v=%b c=%0d d=%h exp v=1 c=5 d=155", frame_valid, frame_count, frame_data); end
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (test_has_ended !== 1'b0 || tm_ready !== 1'b0)
      begin n_err++; $display("FAIL drain_blocked got ended=%b rdy=%b exp ended=0 rdy=0", test_has_ended, tm_ready); end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      tick();
      if (test_has_ended === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL drain_ended_timeout got=0 exp=1"); end
    test_ending = 1'b0;
    tick(); tick();
    n_cmp++; if (test_has_ended !== 1'b1 || tm_ready !== 1'b0)
      begin n_err++; $display("FAIL ended_sticky got ended=%b rdy=%b exp ended=1 rdy=0", test_has_ended, tm_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (test_has_ended !== 1'b0 || tm_ready !== 1'b1)
      begin n_err++; $display("FAIL ended_reset got ended=%b rdy=%b exp ended=0 rdy=1", test_has_ended, tm_ready); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_idle_flush();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/qs_nios2_oci_dct_packer.md
Name: qs_nios2_oci_dct_packer

Overview:
Upstream stage of the Nios II OCI test-bench monitor. Packs a stream of 2-bit trace codes into a 30-bit data-capture-trace (DCT) word of up to 15 units, and emits full or flushed frames through a one-deep valid/ready output register. Exposes the live accumulator as dct_buffer/dct_count for the OCI test bench. Sequences the test_ending to test_has_ended shutdown so the bench sees ending only after all trace has drained.

Parameters:
UNIT_W, 2, bits per trace code
UNITS, 15, units per frame (buffer width = UNIT_W*UNITS = 30)
IDLE_FLUSH, 64, cycles without an accepted code before a partial buffer auto-flushes; 0 disables

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tm_valid  in  1  trace code valid
tm_code  in  2  trace code
tm_ready  out  1  packer accepts tm_code this cycle
flush_req  in  1  single-cycle request to emit the partial buffer
test_ending  in  1  level; begins end-of-test drain
frame_valid  out  1  output frame valid
frame_data  out  30  packed frame; newest unit in bits [1:0]
frame_count  out  4  valid units in frame_data, 1..15
frame_ready  in  1  consumer accepts frame
dct_buffer  out  30  live accumulator contents
dct_count  out  4  live accumulator unit count, 0..15
test_has_ended  out  1  sticky; drain complete

Behaviour:
- Reset: frame_valid=0, frame_data=0, frame_count=0, dct_buffer=0, dct_count=0, test_has_ended=0, tm_ready=0 for the reset cycle, state=RUN, idle counter=0.
- Accept: tm_valid&tm_ready. dct_buffer <= {dct_buffer[27:0], tm_code}. dct_count <= dct_count+1.
- out_free = !frame_valid | frame_ready.
- Transfer: fires when dct_count==15 and out_free, or when a flush is pending, dct_count>0 and out_free. Action: frame_data<=dct_buffer, frame_count<=dct_count, frame_valid<=1. Accumulator clears.
- Accept during a transfer cycle: accumulator becomes {28'b0, tm_code} with count 1. There are no bubbles, so one frame per 15 accepts is sustained.
- frame_valid drops when frame_ready is high and no transfer occurs in the same cycle.
- frame_data and frame_count are held stable while frame_valid & !frame_ready.
- tm_ready = (state==RUN) & (dct_count!=15 | out_free). This is combinational from registers and frame_ready.
- Flush pending: set by flush_req, by the idle counter reaching IDLE_FLUSH with dct_count>0, or by state DRAIN. Cleared when the transfer fires or when dct_count==0. A flush_req with an empty buffer is dropped and no frame is emitted.
- Idle counter: clears on accept or transfer, otherwise increments, saturating at IDLE_FLUSH.
- FSM:
  - RUN: goes to DRAIN when test_ending=1.
  - DRAIN: tm_ready=0. Flushes any partial buffer. Goes to ENDED when dct_count==0 and frame_valid==0.
  - ENDED: test_has_ended=1 and tm_ready=0. Held until reset; test_ending deassertion is ignored.
- Simultaneous test_ending and an accept in RUN: the code is accepted and included in the drain.
- A reset mid-frame discards the accumulator and the output register. No partial frame is emitted.

Decomposition:
- Shared package qs_nios2_oci_pkg: UNIT_W, UNITS, DCT_W=30, DCT_CNT_W=4, state enum {RUN, DRAIN, ENDED}.
- One sub-module, qs_nios2_oci_dct_outreg: the one-deep valid/ready output register with a load port. The packer holds the accumulator, idle counter and FSM.

Test Plan:
- 15 codes 2'b01 back-to-back, frame_ready=1 -> one cycle after the 15th accept: frame_valid=1, frame_data=30'h15555555, frame_count=15; dct_count=0.
- 30 consecutive codes with frame_ready=1 -> tm_ready stays 1 throughout; two frames are emitted; the 16th code appears as dct_count=1 in the same cycle as the first frame.
- frame_ready=0, feed 15 codes, then a 16th -> the first frame loads; tm_ready=1 for the 16th; after the second fill tm_ready=0, data is held stable, and dct_count=15; raise frame_ready -> both frames drain in order.
- Feed codes 3,2,1, then flush_req -> frame_data=30'h39, frame_count=3. A flush_req with an empty buffer -> no frame.
- IDLE_FLUSH=8: feed 1 code, then idle -> frame_count=1 emitted after 8 idle cycles.
- Feed 5 codes, then raise test_ending with frame_ready=0 -> tm_ready=0 and test_has_ended=0 until frame_ready is pulsed. After the frame is consumed, test_has_ended=1 next cycle and stays high after test_ending drops. Reset -> test_has_ended=0.
